// File: rtl/vreg_file_mp_if.sv
// ---------------------------------------------------------------------------
// vreg_file_mp_if
// Bus bundle between the decoder/writeback side (master) and the vector
// register file (slave).
//
// Signals:
//   RE, A1, A2        read request and the two read addresses
//   RD1, RD2          registered read data
//   RVALID            RD1/RD2/HAZ1/HAZ2 valid
//   HAZ1, HAZ2        the addressed register was busy at read time
//   WE, A3, WB, WMASK write enable, address, data and per-lane mask
//   RSV, RSV_A        reserve (mark busy) request and its address
//   BUSY              registered scoreboard vector
//   ERR               sticky illegal-address flag
//
// Handshake: there is no back-pressure. RE, WE and RSV are one-cycle
// requests that are always accepted on the rising edge where they are high.
// RVALID is RE delayed by exactly one cycle and qualifies RD1/RD2/HAZ1/HAZ2
// for that single cycle only.
// ---------------------------------------------------------------------------
interface vreg_file_mp_if #(
   parameter int VLEN  = 256,
   parameter int NREG  = 8,
   parameter int LANES = 8
);
   logic             RE;
   logic [4:0]       A1;
   logic [4:0]       A2;
   logic [VLEN-1:0]  RD1;
   logic [VLEN-1:0]  RD2;
   logic             RVALID;
   logic             HAZ1;
   logic             HAZ2;
   logic             WE;
   logic [4:0]       A3;
   logic [VLEN-1:0]  WB;
   logic [LANES-1:0] WMASK;
   logic             RSV;
   logic [4:0]       RSV_A;
   logic [NREG-1:0]  BUSY;
   logic             ERR;

   modport master (
      output RE, A1, A2, WE, A3, WB, WMASK, RSV, RSV_A,
      input  RD1, RD2, RVALID, HAZ1, HAZ2, BUSY, ERR
   );

   modport slave (
      input  RE, A1, A2, WE, A3, WB, WMASK, RSV, RSV_A,
      output RD1, RD2, RVALID, HAZ1, HAZ2, BUSY, ERR
   );
endinterface

// File: rtl/vreg_file_mp.sv
// ---------------------------------------------------------------------------
// vreg_file_mp
// Parametrised vector register file for the SIMD datapath: two registered
// read ports, one lane-masked write port with same-cycle write-to-read
// bypass, a per-register busy scoreboard with hazard reporting and a sticky
// illegal-address flag.
//
// Ports:
//   RST     asynchronous reset, active low
//   CLK_DC  clock, all state updates on the rising edge
//   bus     vreg_file_mp_if.slave (read, write, reserve, status signals)
// ---------------------------------------------------------------------------
module vreg_file_mp #(
   parameter int VLEN    = 256,
   parameter int NREG    = 8,
   parameter int LANE_W  = 32,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic RST,
   input  logic CLK_DC,
   vreg_file_mp_if.slave bus
);

   localparam int LANES = VLEN / LANE_W;
   localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1;

   logic [VLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy_q;
   logic [VLEN-1:0] rd1_q, rd2_q;
   logic            rvalid_q, haz1_q, haz2_q, err_q;

   logic            a1_ok, a2_ok, a3_ok, rsv_ok;
   logic            wr_hit;
   logic [VLEN-1:0] lane_mask;
   logic [VLEN-1:0] old1, old2, wr_old, merged;
   logic [VLEN-1:0] rd1_nxt, rd2_nxt;
   logic [NREG-1:0] busy_clr, busy_nxt;
   logic            haz1_nxt, haz2_nxt, err_nxt;

   // Full 5-bit compare: addresses at or above NREG never alias.
   function automatic logic legal(input logic [4:0] a);
      return int'(a) < NREG;
   endfunction

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i*LANE_W +: LANE_W] = {LANE_W{bus.WMASK[i]}};
      end
   end

   always_comb begin
      a1_ok  = legal(bus.A1);
      a2_ok  = legal(bus.A2);
      a3_ok  = legal(bus.A3);
      rsv_ok = legal(bus.RSV_A);

      // A write that actually changes storage (reg 0 is read-only zero
      // when ZERO_R0 is set).
      wr_hit = bus.WE && a3_ok && !(ZERO_R0 && bus.A3 == 5'd0);

      old1 = '0;
      if (a1_ok && !(ZERO_R0 && bus.A1 == 5'd0)) old1 = regs[bus.A1[IW-1:0]];
      old2 = '0;
      if (a2_ok && !(ZERO_R0 && bus.A2 == 5'd0)) old2 = regs[bus.A2[IW-1:0]];
      wr_old = '0;
      if (wr_hit) wr_old = regs[bus.A3[IW-1:0]];

      merged = (wr_old & ~lane_mask) | (bus.WB & lane_mask);

      // Bypass: a read of the register being written sees the merged value.
      rd1_nxt = (wr_hit && bus.A1 == bus.A3) ? merged : old1;
      rd2_nxt = (wr_hit && bus.A2 == bus.A3) ? merged : old2;

      // Hazards see the write clear but not the same-cycle reserve.
      busy_clr = busy_q;
      if (bus.WE && a3_ok) busy_clr[bus.A3[IW-1:0]] = 1'b0;
      haz1_nxt = a1_ok ? busy_clr[bus.A1[IW-1:0]] : 1'b0;
      haz2_nxt = a2_ok ? busy_clr[bus.A2[IW-1:0]] : 1'b0;

      // Reserve is applied after the clear so a new producer wins.
      busy_nxt = busy_clr;
      if (bus.RSV && rsv_ok) busy_nxt[bus.RSV_A[IW-1:0]] = 1'b1;
      if (ZERO_R0) busy_nxt[0] = 1'b0;

      err_nxt = err_q
              | (bus.RE  && (!a1_ok || !a2_ok))
              | (bus.WE  && !a3_ok)
              | (bus.RSV && !rsv_ok);
   end

   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
         busy_q   <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         rvalid_q <= 1'b0;
         haz1_q   <= 1'b0;
         haz2_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (wr_hit) regs[bus.A3[IW-1:0]] <= merged;
         busy_q   <= busy_nxt;
         err_q    <= err_nxt;
         rvalid_q <= bus.RE;
         if (bus.RE) begin
            rd1_q  <= rd1_nxt;
            rd2_q  <= rd2_nxt;
            haz1_q <= haz1_nxt;
            haz2_q <= haz2_nxt;
         end
      end
   end

   assign bus.RD1    = rd1_q;
   assign bus.RD2    = rd2_q;
   assign bus.RVALID = rvalid_q;
   assign bus.HAZ1   = haz1_q;
   assign bus.HAZ2   = haz2_q;
   assign bus.BUSY   = busy_q;
   assign bus.ERR    = err_q;

endmodule

// File: tb/tb_vreg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_vreg_file_mp
// Self-checking bench for vreg_file_mp: directed steps followed by random
// traffic, checked against a lane-level reference model of the register
// file contents, scoreboard and error flag.
// ---------------------------------------------------------------------------
module tb_vreg_file_mp;

   localparam int VLEN    = 256;
   localparam int NREG    = 8;
   localparam int LANE_W  = 32;
   localparam int LANES   = VLEN / LANE_W;
   localparam bit ZERO_R0 = 1'b0;

   logic RST;
   logic CLK_DC;

   vreg_file_mp_if #(.VLEN(VLEN), .NREG(NREG), .LANES(LANES)) bus ();

   vreg_file_mp #(
      .VLEN(VLEN), .NREG(NREG), .LANE_W(LANE_W), .ZERO_R0(ZERO_R0)
   ) dut (
      .RST(RST),
      .CLK_DC(CLK_DC),
      .bus(bus)
   );

   // clock / reset
   initial CLK_DC = 1'b0;
   always #5 CLK_DC = ~CLK_DC;

   // reference model state
   logic [VLEN-1:0] m_regs [32];
   bit   [31:0]     m_busy;
   bit              m_err;
   logic [VLEN-1:0] exp_rd1, exp_rd2;
   bit              exp_rvalid, exp_haz1, exp_haz2;

   int vectors  = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [VLEN-1:0] got,
                      input logic [VLEN-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
      m_err  = 1'b0;
      exp_rd1 = '0;
      exp_rd2 = '0;
      exp_rvalid = 1'b0;
      exp_haz1 = 1'b0;
      exp_haz2 = 1'b0;
   endtask

   function automatic bit is_legal(input int a);
      return a < NREG;
   endfunction

   // Value a read of address a returns, including a same-cycle write.
   function automatic logic [VLEN-1:0] model_read(input int a, input bit we,
         input int a3, input logic [VLEN-1:0] wb, input logic [LANES-1:0] wm);
      logic [VLEN-1:0] v;
      if (!is_legal(a) || (ZERO_R0 && a == 0)) return '0;
      v = m_regs[a];
      if (we && a3 == a)
         for (int l = 0; l < LANES; l++)
            if (wm[l]) v[l*LANE_W +: LANE_W] = wb[l*LANE_W +: LANE_W];
      return v;
   endfunction

   function automatic bit model_haz(input int a, input bit we, input int a3);
      if (!is_legal(a)) return 1'b0;
      if (we && a3 == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check_all();
      chk("RVALID", VLEN'(bus.RVALID), VLEN'(exp_rvalid));
      chk("RD1",    bus.RD1, exp_rd1);
      chk("RD2",    bus.RD2, exp_rd2);
      chk("HAZ1",   VLEN'(bus.HAZ1), VLEN'(exp_haz1));
      chk("HAZ2",   VLEN'(bus.HAZ2), VLEN'(exp_haz2));
      chk("BUSY",   VLEN'(bus.BUSY), VLEN'(m_busy[NREG-1:0]));
      chk("ERR",    VLEN'(bus.ERR), VLEN'(m_err));
   endtask

   // driver: apply one cycle of inputs (called just after a negedge)
   task automatic cyc(input bit re, input int a1, input int a2,
                      input bit we, input int a3, input logic [VLEN-1:0] wb,
                      input logic [LANES-1:0] wm, input bit rsv, input int ra);
      bus.RE = re;   bus.A1 = 5'(a1);  bus.A2 = 5'(a2);
      bus.WE = we;   bus.A3 = 5'(a3);  bus.WB = wb;  bus.WMASK = wm;
      bus.RSV = rsv; bus.RSV_A = 5'(ra);
      // predict from pre-edge state, then commit the model
      exp_rvalid = re;
      if (re) begin
         exp_rd1  = model_read(a1, we, a3, wb, wm);
         exp_rd2  = model_read(a2, we, a3, wb, wm);
         exp_haz1 = model_haz(a1, we, a3);
         exp_haz2 = model_haz(a2, we, a3);
         if (!is_legal(a1) || !is_legal(a2)) m_err = 1'b1;
      end
      if (we) begin
         if (!is_legal(a3)) m_err = 1'b1;
         else begin
            if (!(ZERO_R0 && a3 == 0)) m_regs[a3] = model_read(a3, 1'b1, a3, wb, wm);
            m_busy[a3] = 1'b0;
         end
      end
      if (rsv) begin
         if (!is_legal(ra)) m_err = 1'b1;
         else m_busy[ra] = 1'b1;
      end
      if (ZERO_R0) m_busy[0] = 1'b0;
      @(posedge CLK_DC);
      @(negedge CLK_DC);
      check_all();
   endtask

   task automatic idle();
      cyc(1'b0, 0, 0, 1'b0, 0, '0, '0, 1'b0, 0);
   endtask

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      for (int l = 0; l < VLEN / 32; l++) v[l*32 +: 32] = $urandom;
      return v;
   endfunction

   // Mostly legal addresses, occasionally illegal.
   function automatic int rand_addr(input bit allow_bad);
      if (allow_bad && $urandom_range(0, 15) == 0) return $urandom_range(NREG, 31);
      return $urandom_range(0, NREG - 1);
   endfunction

   logic [VLEN-1:0] wb_a, wb_ff, exp_mix, reg4_before;

   initial begin
      // reset
      RST = 1'b0;
      bus.RE = 1'b0; bus.A1 = '0; bus.A2 = '0; bus.WE = 1'b0; bus.A3 = '0;
      bus.WB = '0; bus.WMASK = '0; bus.RSV = 1'b0; bus.RSV_A = '0;
      model_reset();
      repeat (2) @(negedge CLK_DC);
      check_all();
      RST = 1'b1;
      @(negedge CLK_DC);

      // read after reset: zeros, no hazards
      cyc(1'b1, 3, 7, 1'b0, 0, '0, '0, 1'b0, 0);
      chk("RST_RD1", bus.RD1, '0);

      // full-mask write then partial-mask overwrite
      for (int l = 0; l < LANES; l++) wb_a[l*LANE_W +: LANE_W] = 32'h11111111 * (l + 1);
      wb_ff = '1;
      cyc(1'b0, 0, 0, 1'b1, 2, wb_a, 8'hFF, 1'b0, 0);
      cyc(1'b0, 0, 0, 1'b1, 2, wb_ff, 8'h0F, 1'b0, 0);
      cyc(1'b1, 2, 0, 1'b0, 0, '0, '0, 1'b0, 0);
      for (int l = 0; l < LANES; l++)
         exp_mix[l*LANE_W +: LANE_W] = (l < 4) ? 32'hFFFFFFFF : 32'h11111111 * (l + 1);
      chk("MASK_RD1", bus.RD1, exp_mix);

      // same-cycle bypass to both ports
      cyc(1'b1, 5, 5, 1'b1, 5, {32{8'hA5}}, 8'hFF, 1'b0, 0);
      chk("BYP_RD1", bus.RD1, {32{8'hA5}});
      chk("BYP_RD2", bus.RD2, {32{8'hA5}});

      // reserve, hazard, clear with an empty-mask write
      cyc(1'b0, 0, 0, 1'b1, 4, rand_vec(), 8'hFF, 1'b1, 4);
      reg4_before = m_regs[4];
      cyc(1'b1, 4, 0, 1'b0, 0, '0, '0, 1'b0, 0);
      chk("RSV_HAZ1", VLEN'(bus.HAZ1), VLEN'(1'b1));
      cyc(1'b0, 0, 0, 1'b1, 4, rand_vec(), 8'h00, 1'b0, 0);
      chk("CLR_BUSY4", VLEN'(bus.BUSY[4]), VLEN'(1'b0));
      cyc(1'b1, 4, 4, 1'b0, 0, '0, '0, 1'b0, 0);
      chk("NOMASK_R4", bus.RD1, reg4_before);

      // reserve and write the same register in one cycle
      cyc(1'b1, 6, 1, 1'b1, 6, rand_vec(), 8'hA5, 1'b1, 6);
      chk("RSVWIN_BUSY6", VLEN'(bus.BUSY[6]), VLEN'(1'b1));
      chk("RSVWIN_HAZ1", VLEN'(bus.HAZ1), VLEN'(1'b0));
      cyc(1'b1, 6, 6, 1'b0, 0, '0, '0, 1'b0, 0);

      // random traffic, legal addresses only so ERR stays observable later
      for (int n = 0; n < 300; n++)
         cyc(1'($urandom_range(0, 1)), rand_addr(1'b0), rand_addr(1'b0),
             1'($urandom_range(0, 1)), rand_addr(1'b0), rand_vec(),
             LANES'($urandom), 1'($urandom_range(0, 2) == 0), rand_addr(1'b0));

      // illegal read address
      cyc(1'b1, 9, 1, 1'b0, 0, '0, '0, 1'b0, 0);
      chk("BAD_RD1", bus.RD1, '0);
      chk("BAD_ERR", VLEN'(bus.ERR), VLEN'(1'b1));
      // illegal write and reserve: no effect beyond ERR
      cyc(1'b0, 0, 0, 1'b1, 12, rand_vec(), 8'hFF, 1'b1, 20);
      for (int r = 0; r < NREG; r += 2) cyc(1'b1, r, r + 1, 1'b0, 0, '0, '0, 1'b0, 0);

      // random traffic including illegal addresses
      for (int n = 0; n < 100; n++)
         cyc(1'($urandom_range(0, 1)), rand_addr(1'b1), rand_addr(1'b1),
             1'($urandom_range(0, 1)), rand_addr(1'b1), rand_vec(),
             LANES'($urandom), 1'($urandom_range(0, 2) == 0), rand_addr(1'b1));

      // asynchronous reset mid-stream, away from any clock edge
      bus.RE = 1'b1; bus.A1 = 5'd1; bus.WE = 1'b1; bus.A3 = 5'd1;
      bus.WMASK = '1; bus.RSV = 1'b1; bus.RSV_A = 5'd3;
      #2 RST = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge CLK_DC);
      RST = 1'b1;
      for (int r = 0; r < NREG; r += 2) cyc(1'b1, r, r + 1, 1'b0, 0, '0, '0, 1'b0, 0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vreg_file_mp.md
Name: vreg_file_mp

Overview:
Parametrised vector register file for the SIMD datapath. It generalises the fixed 6-entry, 256-bit, 2-read/1-write register bank used at decode/writeback, adding:
- configurable depth and width
- per-lane write masking
- same-cycle write-to-read bypass
- a per-register busy scoreboard with hazard reporting
- illegal-address detection

Reads and writes share the single decode clock CLK_DC. The block sits between the decoder (read/reserve side) and the writeback stage (write side).

Parameters:
VLEN, 256, vector register width in bits; must be a multiple of LANE_W.
NREG, 8, number of implemented registers (2..32).
LANE_W, 32, bits per write-mask lane; LANES = VLEN/LANE_W.
ZERO_R0, 0, when 1, register 0 always reads zero, ignores writes and is never busy.

Ports:
RST  input  1  asynchronous reset, active low
CLK_DC  input  1  clock, all state updates on rising edge
RE  input  1  read request for A1/A2 this cycle
A1  input  5  read address port 1
A2  input  5  read address port 2
RD1  output  VLEN  registered read data port 1
RD2  output  VLEN  registered read data port 2
RVALID  output  1  RD1/RD2/HAZ1/HAZ2 valid (RE delayed one cycle)
HAZ1  output  1  register A1 was busy at read time
HAZ2  output  1  register A2 was busy at read time
WE  input  1  write enable
A3  input  5  write address
WB  input  VLEN  write data
WMASK  input  LANES  per-lane write enable; lane i = WB[i*LANE_W +: LANE_W]
RSV  input  1  reserve (mark busy) register RSV_A
RSV_A  input  5  reserve address
BUSY  output  NREG  current scoreboard vector, registered
ERR  output  1  sticky illegal-address flag

Behaviour:
- Reset (RST low, async) sets the following to zero:
  - all registers, BUSY, RD1, RD2, RVALID, HAZ1, HAZ2, ERR.
  - Reset asserted mid-operation discards pending reads and reservations immediately.
- Address legality: an address is legal iff < NREG. Only the full 5-bit value is compared; there is no truncation or aliasing.
- Read, 1-cycle latency:
  - On an edge with RE=1, RD1/RD2 load the contents of A1/A2 and RVALID=1 the next cycle.
  - With RE=0, RD1/RD2 hold their value and RVALID=0.
- Illegal read address: that port returns all zeros and its HAZ=0.
- ZERO_R0=1: a read of register 0 returns zero.
- Bypass: if WE=1 and A3==A1 (legal) in the same cycle as RE=1, RD1 gets the merged value:
  - lanes with WMASK=1 take WB;
  - the remaining lanes keep the old register contents.
  - The same applies to A2/RD2, and to both ports when both match.
- Write: on an edge with WE=1 and A3 legal (and not reg 0 when ZERO_R0=1), lanes with WMASK[i]=1 are updated. WMASK=0 leaves the register unchanged, but the write still counts for scoreboard clearing.
- Scoreboard:
  - A WE to a legal A3 clears BUSY[A3].
  - RSV=1 to a legal RSV_A sets BUSY[RSV_A].
  - If both target the same register in the same cycle, the reserve wins and BUSY stays 1 (new producer).
  - RSV to an already-busy register keeps it busy; there is no count.
  - ZERO_R0=1: BUSY[0] is forced to 0.
- Hazard: HAZ1/HAZ2 are sampled with the read and equal BUSY[A] after applying the same-cycle write clear, but before the same-cycle reserve.
  - Reading a register that is written this cycle gives HAZ=0 plus bypassed data.
  - Reading a register that is reserved this cycle gives HAZ=0.
- ERR is set, sticky until reset, when any of the following occurs:
  - RE=1 with illegal A1 or A2;
  - WE=1 with illegal A3;
  - RSV=1 with illegal RSV_A.
  Illegal writes and reserves have no other effect.

Test Plan:
- Reset then RE=1, A1=3, A2=7 -> next cycle RVALID=1, RD1=RD2=0, HAZ1=HAZ2=0, BUSY=0.
- WE=1, A3=2, WB=lanes 0..7 = 32'h11111111 x (i+1), WMASK=8'hFF; next cycle WE=1, A3=2, WB=all 32'hFFFFFFFF, WMASK=8'h0F; then read A1=2 -> RD1 lanes 0-3 = 32'hFFFFFFFF, lanes 4-7 = 32'h55555555..32'h88888888.
- Same cycle WE=1, A3=5, WB=256'hA5 repeated, WMASK=8'hFF and RE=1, A1=5, A2=5 -> next cycle RD1=RD2=256'hA5 repeated (bypass).
- RSV=1, RSV_A=4; next cycle read A1=4 -> HAZ1=1, BUSY[4]=1. Then WE=1, A3=4, WMASK=0 -> BUSY[4]=0, register 4 contents unchanged.
- Same-cycle RSV=1, RSV_A=6 and WE=1, A3=6 -> BUSY[6]=1 and register 6 updated.
- NREG=8: RE=1, A1=9 -> RD1=0, ERR=1 and held. WE=1, A3=12 -> no register changes. Pulse RST low mid-stream -> all outputs 0 asynchronously.
